mem_port_arbiter: RTL and testbench

- Sequences the single-port instruction/data memory, which has one request per cycle and a registered read.
- Shares it between two requesters:
  - port 0: instruction fetch, read-only;
  - port 1: load/store, read/write.
- Round-robin arbitration, one outstanding transaction at a time.
- A fixed-latency wait counter times the read capture; the memory's status bit is not used.

---
 rtl/mem_port_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port, registered-read memory between
// an instruction-fetch port (read-only) and a load/store port (read/write).
module mem_port_arbiter #(
  parameter  int MEM_DEPTH   = 8,
  parameter  int DATA_WIDTH  = 32,
  parameter  int MEM_LATENCY = 1,
  localparam int ADDR_WIDTH  = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  p0_req,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  output logic                  p0_gnt,
  output logic                  p0_rvalid,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p1_gnt,
  output logic                  p1_rvalid,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic                  mem_req_valid,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  localparam int WCNT_W = $clog2(MEM_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                state_q, state_d;
  logic [WCNT_W-1:0]     wcnt_q, wcnt_d;
  logic                  last_q, last_d;
  logic                  hold_id_q, hold_id_d;
  logic                  hold_we_q, hold_we_d;
  logic                  p0_gnt_q, p0_gnt_d;
  logic                  p1_gnt_q, p1_gnt_d;
  logic                  p0_rvalid_q, p0_rvalid_d;
  logic                  p1_rvalid_q, p1_rvalid_d;
  logic [DATA_WIDTH-1:0] p0_rdata_q, p0_rdata_d;
  logic [DATA_WIDTH-1:0] p1_rdata_q, p1_rdata_d;
  logic                  mem_req_valid_q, mem_req_valid_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  busy_q, busy_d;

  logic req_any;
  logic win;

  assign req_any = p0_req | p1_req;
  // On a tie the port that was not granted last wins.
  assign win     = (p0_req & p1_req) ? ~last_q : p1_req;

  always_comb begin
    state_d         = state_q;
    wcnt_d          = wcnt_q;
    last_d          = last_q;
    hold_id_d       = hold_id_q;
    hold_we_d       = hold_we_q;
    p0_gnt_d        = 1'b0;
    p1_gnt_d        = 1'b0;
    p0_rvalid_d     = 1'b0;
    p1_rvalid_d     = 1'b0;
    p0_rdata_d      = p0_rdata_q;
    p1_rdata_d      = p1_rdata_q;
    mem_req_valid_d = 1'b0;
    mem_we_d        = 1'b0;
    mem_addr_d      = '0;
    mem_wdata_d     = '0;

    unique case (state_q)
      IDLE, RESP: begin
        if (req_any) begin
          state_d         = ISSUE;
          last_d          = win;
          hold_id_d       = win;
          hold_we_d       = win & p1_we;
          p0_gnt_d        = ~win;
          p1_gnt_d        = win;
          mem_req_valid_d = 1'b1;
          mem_we_d        = win & p1_we;
          mem_addr_d      = win ? p1_addr : p0_addr;
          mem_wdata_d     = win ? p1_wdata : '0;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        wcnt_d  = WCNT_W'(MEM_LATENCY - 1);
      end
      WAIT: begin
        if (wcnt_q == '0) begin
          state_d     = RESP;
          p0_rvalid_d = ~hold_id_q;
          p1_rvalid_d = hold_id_q;
          if (!hold_we_q) begin
            if (hold_id_q) p1_rdata_d = mem_rdata;
            else           p0_rdata_d = mem_rdata;
          end
        end else begin
          wcnt_d = wcnt_q - WCNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      wcnt_q          <= '0;
      last_q          <= 1'b1;
      hold_id_q       <= 1'b0;
      hold_we_q       <= 1'b0;
      p0_gnt_q        <= 1'b0;
      p1_gnt_q        <= 1'b0;
      p0_rvalid_q     <= 1'b0;
      p1_rvalid_q     <= 1'b0;
      p0_rdata_q      <= '0;
      p1_rdata_q      <= '0;
      mem_req_valid_q <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      wcnt_q          <= wcnt_d;
      last_q          <= last_d;
      hold_id_q       <= hold_id_d;
      hold_we_q       <= hold_we_d;
      p0_gnt_q        <= p0_gnt_d;
      p1_gnt_q        <= p1_gnt_d;
      p0_rvalid_q     <= p0_rvalid_d;
      p1_rvalid_q     <= p1_rvalid_d;
      p0_rdata_q      <= p0_rdata_d;
      p1_rdata_q      <= p1_rdata_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_we_q        <= mem_we_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      busy_q          <= busy_d;
    end
  end

  assign p0_gnt        = p0_gnt_q;
  assign p1_gnt        = p1_gnt_q;
  assign p0_rvalid     = p0_rvalid_q;
  assign p1_rvalid     = p1_rvalid_q;
  assign p0_rdata      = p0_rdata_q;
  assign p1_rdata      = p1_rdata_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table on a
// MEM_LATENCY=1 instance with a memory model, plus a MEM_LATENCY=3 sequence.
module tb_mem_port_arbiter;

  localparam logic [31:0] FW = 32'h00730e33;
  localparam logic [31:0] DB = 32'hDEADBEEF;
  localparam logic [31:0] M3 = 32'hA0000003;
  localparam logic [31:0] M5 = 32'hA0000005;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // MEM_LATENCY = 1 instance
  logic        reset, p0_req, p1_req, p1_we;
  logic [2:0]  p0_addr, p1_addr, mem_addr;
  logic [31:0] p1_wdata, p0_rdata, p1_rdata, mem_wdata, mem_rdata;
  logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_req_valid, mem_we, busy;

  mem_port_arbiter #(.MEM_DEPTH(8), .DATA_WIDTH(32), .MEM_LATENCY(1)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_gnt(p0_gnt),
    .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_req_valid(mem_req_valid), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  // Single-port memory with registered read
  logic [31:0] mem [8];
  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 32'hA0000000 | i;
    mem[2]    = FW;
    mem_rdata = '0;
  end
  always @(posedge clk) begin
    if (mem_req_valid) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  // MEM_LATENCY = 3 instance, mem_rdata driven directly by the bench
  logic        r3, q0, q1, q1we;
  logic [2:0]  q0a, q1a, x_maddr;
  logic [31:0] q1wd, x_rd0, x_rd1, x_mwd, t_rd;
  logic        x_g0, x_g1, x_v0, x_v1, x_mv, x_mwe, x_busy;

  mem_port_arbiter #(.MEM_DEPTH(8), .DATA_WIDTH(32), .MEM_LATENCY(3)) dut3 (
    .clk(clk), .reset(r3),
    .p0_req(q0), .p0_addr(q0a), .p0_gnt(x_g0),
    .p0_rvalid(x_v0), .p0_rdata(x_rd0),
    .p1_req(q1), .p1_we(q1we), .p1_addr(q1a), .p1_wdata(q1wd),
    .p1_gnt(x_g1), .p1_rvalid(x_v1), .p1_rdata(x_rd1),
    .mem_req_valid(x_mv), .mem_we(x_mwe), .mem_addr(x_maddr),
    .mem_wdata(x_mwd), .mem_rdata(t_rd), .busy(x_busy)
  );

  typedef struct {
    logic        rst, chk, r0;
    logic [2:0]  a0;
    logic        r1, we;
    logic [2:0]  a1;
    logic [31:0] wd;
    logic        g0, g1, v0, v1, mv, mwe;
    logic [2:0]  maddr;
    logic [31:0] mwd;
    logic        bsy;
    logic [31:0] rd0, rd1;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mkv(
    input logic rst, chk, r0, input logic [2:0] a0,
    input logic r1, we, input logic [2:0] a1, input logic [31:0] wd,
    input logic g0, g1, v0, v1, mv, mwe, input logic [2:0] maddr,
    input logic [31:0] mwd, input logic bsy, input logic [31:0] rd0, rd1);
    vec_t v;
    v.rst = rst; v.chk = chk; v.r0 = r0; v.a0 = a0; v.r1 = r1; v.we = we;
    v.a1 = a1; v.wd = wd; v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1;
    v.mv = mv; v.mwe = mwe; v.maddr = maddr; v.mwd = mwd; v.bsy = bsy;
    v.rd0 = rd0; v.rd1 = rd1;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd0c, rd1c;
    logic        w;
    logic [2:0]  wa;
    logic        hold;

    reset = 1'b1; p0_req = 0; p0_addr = 0; p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
    r3 = 1'b1; q0 = 0; q0a = 0; q1 = 0; q1we = 0; q1a = 0; q1wd = 0; t_rd = 0;

    //            rst chk r0 a0 r1 we a1 wd   g0 g1 v0 v1 mv mwe ma mwd bsy rd0 rd1
    vq.push_back(mkv(1, 0, 1, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0,  0, 0,  0));
    vq.push_back(mkv(1, 1, 1, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0,  0, 0,  0));
    vq.push_back(mkv(0, 1, 1, 2, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0,  0, 0,  0));
    vq.push_back(mkv(0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 0, 2, 0,  1, 0,  0));
    vq.push_back(mkv(0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0,  1, 0,  0));
    vq.push_back(mkv(0, 1, 0, 0, 1, 1, 6, DB, 0, 0, 1, 0, 0, 0, 0, 0,  1, FW, 0));
    vq.push_back(mkv(0, 1, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 1, 1, 6, DB, 1, FW, 0));
    vq.push_back(mkv(0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0,  1, FW, 0));
    vq.push_back(mkv(0, 1, 0, 0, 1, 0, 6, 0,  0, 0, 0, 1, 0, 0, 0, 0,  1, FW, 0));
    vq.push_back(mkv(0, 1, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 1, 0, 6, 0,  1, FW, 0));
    vq.push_back(mkv(0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0,  1, FW, 0));
    vq.push_back(mkv(0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0, 0,  1, FW, DB));
    vq.push_back(mkv(0, 1, 1, 3, 1, 0, 5, 0,  0, 0, 0, 0, 0, 0, 0, 0,  0, FW, DB));
    // Both ports held: grants alternate p0,p1,... every 3 cycles, RESP->ISSUE direct
    rd0c = FW; rd1c = DB;
    for (int k = 0; k < 6; k++) begin
      w    = k[0];
      wa   = w ? 3'd5 : 3'd3;
      hold = (k != 5);
      vq.push_back(mkv(0, 1, 1, 3, 1, 0, 5, 0, !w, w, 0, 0, 1, 0, wa, 0, 1, rd0c, rd1c));
      vq.push_back(mkv(0, 1, 1, 3, 1, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, rd0c, rd1c));
      if (w) rd1c = M5; else rd0c = M3;
      vq.push_back(mkv(0, 1, hold, 3, hold, 0, 5, 0, 0, 0, !w, w, 0, 0, 0, 0, 1, rd0c, rd1c));
    end
    vq.push_back(mkv(0, 1, 0, 0, 1, 0, 6, 0,  0, 0, 0, 0, 0, 0, 0, 0,  0, M3, M5));
    vq.push_back(mkv(0, 1, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 1, 0, 6, 0,  1, M3, M5));
    // Reset during WAIT of the p1 read abandons it
    vq.push_back(mkv(1, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0,  1, M3, M5));
    vq.push_back(mkv(0, 1, 1, 2, 1, 0, 5, 0,  0, 0, 0, 0, 0, 0, 0, 0,  0, 0,  0));
    vq.push_back(mkv(0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 0, 2, 0,  1, 0,  0));
    vq.push_back(mkv(0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0,  1, 0,  0));
    vq.push_back(mkv(0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0, 0,  1, FW, 0));
    vq.push_back(mkv(0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0,  0, FW, 0));

    step();
    foreach (vq[i]) begin
      reset = vq[i].rst; p0_req = vq[i].r0; p0_addr = vq[i].a0;
      p1_req = vq[i].r1; p1_we = vq[i].we; p1_addr = vq[i].a1; p1_wdata = vq[i].wd;
      @(negedge clk);
      if (vq[i].chk) begin
        n_vec++;
        chk("p0_gnt",        i, 32'(p0_gnt),        32'(vq[i].g0));
        chk("p1_gnt",        i, 32'(p1_gnt),        32'(vq[i].g1));
        chk("p0_rvalid",     i, 32'(p0_rvalid),     32'(vq[i].v0));
        chk("p1_rvalid",     i, 32'(p1_rvalid),     32'(vq[i].v1));
        chk("mem_req_valid", i, 32'(mem_req_valid), 32'(vq[i].mv));
        chk("mem_we",        i, 32'(mem_we),        32'(vq[i].mwe));
        chk("mem_addr",      i, 32'(mem_addr),      32'(vq[i].maddr));
        chk("mem_wdata",     i, mem_wdata,          vq[i].mwd);
        chk("busy",          i, 32'(busy),          32'(vq[i].bsy));
        chk("p0_rdata",      i, p0_rdata,           vq[i].rd0);
        chk("p1_rdata",      i, p1_rdata,           vq[i].rd1);
      end
      step();
    end

    // MEM_LATENCY=3: request sampled at E0, gnt in cycle 1, rvalid in cycle 5
    r3 = 1'b0; q0 = 1'b1; q0a = 3'd4; t_rd = 32'hC0DE0000;
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      n_vec++;
      chk("L3 p0_gnt",    c, 32'(x_g0),   32'(c == 1));
      chk("L3 mem_req",   c, 32'(x_mv),   32'(c == 1));
      chk("L3 p0_rvalid", c, 32'(x_v0),   32'(c == 5));
      chk("L3 busy",      c, 32'(x_busy), 32'(c >= 1 && c <= 5));
      chk("L3 p1_gnt",    c, 32'(x_g1),   32'd0);
      if (c == 1) chk("L3 mem_addr", c, 32'(x_maddr), 32'd4);
      if (c == 5) chk("L3 p0_rdata", c, x_rd0, 32'hC0DE0004);
      step();
      q0   = 1'b0;
      t_rd = 32'hC0DE0000 | (c + 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
